// File: rtl/wb_pkg.sv
// Shared constants and encodings for the register-file writeback port arbiter.
package wb_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned WAIT_WIDTH     = 4;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_LSU = 1'b1;

  typedef enum logic {
    LSU_PRI = 1'b0,
    ALU_PRI = 1'b1
  } prio_state_e;

endpackage

// File: rtl/wb_wait_counter.sv
// Saturating wait counter: clear beats increment, otherwise holds.
module wb_wait_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_at_max
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != WIDTH'(MAX))) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_at_max = (r_cnt == WIDTH'(MAX));

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between ALU writeback and
// LSU load return, with a bounded-wait guarantee for the ALU.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = wb_pkg::REG_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = wb_pkg::DATA_WIDTH,
  parameter int unsigned MAX_WAIT       = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  output logic                      alu_ready,
  input  logic                      lsu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]     lsu_data,
  output logic                      lsu_ready,
  input  logic                      wb_stall,
  output logic                      wr_en,
  output logic [REG_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_src,
  output logic [3:0]                alu_wait
);

  prio_state_e r_state, w_state_next;

  logic                      w_alu_ready, w_lsu_ready;
  logic                      w_alu_xfer, w_lsu_xfer, w_xfer, w_write;
  logic                      w_wait_inc, w_wait_at_max;
  logic [WAIT_WIDTH-1:0]     w_wait_cnt;
  logic [REG_ADDR_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0]     w_data;
  logic                      w_src;

  logic                      r_wr_en;
  logic [REG_ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0]     r_wr_data;
  logic                      r_wr_src;

  always_comb begin
    w_alu_ready = 1'b0;
    w_lsu_ready = 1'b0;
    if (!reset && !wb_stall) begin
      if (alu_valid && lsu_valid) begin
        if (r_state == ALU_PRI) w_alu_ready = 1'b1;
        else                    w_lsu_ready = 1'b1;
      end else begin
        w_alu_ready = alu_valid;
        w_lsu_ready = lsu_valid;
      end
    end
  end

  assign w_alu_xfer = alu_valid & w_alu_ready;
  assign w_lsu_xfer = lsu_valid & w_lsu_ready;
  assign w_xfer     = w_alu_xfer | w_lsu_xfer;
  assign w_wait_inc = alu_valid & ~w_alu_ready & ~wb_stall & ~reset;

  wb_wait_counter #(
    .WIDTH (WAIT_WIDTH),
    .MAX   (MAX_WAIT)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (w_wait_inc),
    .i_clr    (w_alu_xfer),
    .o_cnt    (w_wait_cnt),
    .o_at_max (w_wait_at_max)
  );

  // Flip priority in the same cycle the count reaches MAX_WAIT, so the very
  // next contested cycle goes to the ALU.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LSU_PRI: begin
        if (!w_alu_xfer &&
            (w_wait_at_max ||
             (w_wait_inc && (w_wait_cnt == WAIT_WIDTH'(MAX_WAIT - 1)))))
          w_state_next = ALU_PRI;
      end
      ALU_PRI: begin
        if (w_alu_xfer) w_state_next = LSU_PRI;
      end
      default: w_state_next = LSU_PRI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= LSU_PRI;
    else       r_state <= w_state_next;
  end

  assign w_rd    = w_lsu_xfer ? lsu_rd   : alu_rd;
  assign w_data  = w_lsu_xfer ? lsu_data : alu_data;
  assign w_src   = w_lsu_xfer ? WB_SRC_LSU : WB_SRC_ALU;
  assign w_write = w_xfer && (w_rd != '0);

  // Transfers to x0 are consumed but leave the port registers untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_src  <= WB_SRC_ALU;
    end else begin
      r_wr_en <= w_write;
      if (w_write) begin
        r_wr_addr <= w_rd;
        r_wr_data <= w_data;
        r_wr_src  <= w_src;
      end
    end
  end

  assign alu_ready = w_alu_ready;
  assign lsu_ready = w_lsu_ready;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign wr_src    = r_wr_src;
  assign alu_wait  = w_wait_cnt;

endmodule
